bcd_counter_x4: RTL and testbench

BCD_COUNTER_X4 -- requirements
Module: bcd_counter_x4

---
 rtl/bcd_counter_x4.sv | 123 ++++++++++++
 tb/tb_bcd_counter_x4.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_x4.sv
// Four-digit BCD up/down counter with a run-gated prescaler, synchronous clear,
// wrap pulse and registered 7-segment patterns (optional leading-zero blanking).
module bcd_counter_x4 #(
  parameter int unsigned CLK_FREQUENCY = 27000000,
  parameter int unsigned TICK_HZ       = 1,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        clkIn,
  input  logic        resetIn,
  input  logic        runIn,
  input  logic        clearIn,
  input  logic        upIn,
  output logic [15:0] bcdOut,
  output logic [31:0] segmentsOut,
  output logic        tickOut,
  output logic        overflowOut
);

  localparam int unsigned N  = CLK_FREQUENCY / TICK_HZ;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(N - 1);
  localparam logic [31:0]   SEG_RESET = BLANK_LEADING ? 32'h0000_003F : 32'h3F3F_3F3F;

  logic [PW-1:0] prescale;
  logic          tick_now;
  logic [15:0]   bcd_next;
  logic          carry;
  logic [31:0]   seg_next;
  logic          blank_run;
  logic [3:0]    digit;

  // Segment pattern for one BCD digit, {dp,g,f,e,d,c,b,a}, dp always dark
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  assign tick_now = runIn && (prescale == PRE_LAST);

  // Ripple carry/borrow through the digits; carry out of digit3 marks the wrap
  always_comb begin
    bcd_next = bcdOut;
    carry    = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (carry) begin
        if (upIn) begin
          if (bcdOut[4*i +: 4] >= 4'd9) begin
            bcd_next[4*i +: 4] = 4'd0;
          end else begin
            bcd_next[4*i +: 4] = bcdOut[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (bcdOut[4*i +: 4] == 4'd0 || bcdOut[4*i +: 4] > 4'd9) begin
            bcd_next[4*i +: 4] = 4'd9;
          end else begin
            bcd_next[4*i +: 4] = bcdOut[4*i +: 4] - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  // Decode from the most significant digit down, blanking while all higher digits are zero
  always_comb begin
    seg_next  = '0;
    blank_run = 1'b1;
    digit     = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      digit     = bcdOut[4*(3-k) +: 4];
      blank_run = blank_run && (digit == 4'd0);
      if (!(BLANK_LEADING && blank_run && (k != 3))) begin
        seg_next[8*(3-k) +: 8] = seg7(digit);
      end
    end
  end

  // Prescaler, count and event pulses; clear outranks a coincident tick
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      prescale    <= '0;
      bcdOut      <= '0;
      tickOut     <= 1'b0;
      overflowOut <= 1'b0;
    end else if (clearIn) begin
      prescale    <= '0;
      bcdOut      <= '0;
      tickOut     <= 1'b0;
      overflowOut <= 1'b0;
    end else begin
      tickOut     <= tick_now;
      overflowOut <= tick_now && carry;
      if (runIn) begin
        prescale <= tick_now ? '0 : prescale + PW'(1);
      end
      if (tick_now) begin
        bcdOut <= bcd_next;
      end
    end
  end

  // Registered segment patterns, one cycle behind bcdOut
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      segmentsOut <= SEG_RESET;
    end else begin
      segmentsOut <= seg_next;
    end
  end

endmodule

// File: tb/tb_bcd_counter_x4.sv
// Bench for bcd_counter_x4: integer reference model checked every cycle,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_bcd_counter_x4;

  localparam int N = 10;

  logic        clkIn = 1'b0;
  logic        resetIn, runIn, clearIn, upIn;
  logic [15:0] bcdOut, bcd_nb;
  logic [31:0] segmentsOut, seg_nb;
  logic        tickOut, overflowOut, tick_nb, ovf_nb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clkIn = ~clkIn;

  bcd_counter_x4 #(.CLK_FREQUENCY(10), .TICK_HZ(1), .BLANK_LEADING(1'b1)) dut (
    .clkIn(clkIn), .resetIn(resetIn), .runIn(runIn), .clearIn(clearIn), .upIn(upIn),
    .bcdOut(bcdOut), .segmentsOut(segmentsOut), .tickOut(tickOut), .overflowOut(overflowOut)
  );

  bcd_counter_x4 #(.CLK_FREQUENCY(10), .TICK_HZ(1), .BLANK_LEADING(1'b0)) dut_nb (
    .clkIn(clkIn), .resetIn(resetIn), .runIn(runIn), .clearIn(clearIn), .upIn(upIn),
    .bcdOut(bcd_nb), .segmentsOut(seg_nb), .tickOut(tick_nb), .overflowOut(ovf_nb)
  );

  // Reference model: count as a plain integer 0..9999
  int m_cnt = 0, m_pre = 0, m_seg_cnt = 0;
  bit m_tick = 0, m_ovf = 0;

  always @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      m_cnt = 0; m_pre = 0; m_tick = 0; m_ovf = 0; m_seg_cnt = 0;
    end else begin
      m_seg_cnt = m_cnt;
      m_tick = 0; m_ovf = 0;
      if (clearIn) begin
        m_cnt = 0; m_pre = 0;
      end else if (runIn) begin
        if (m_pre == N - 1) begin
          m_pre  = 0;
          m_tick = 1;
          if (upIn) begin
            m_ovf = (m_cnt == 9999);
            m_cnt = (m_cnt + 1) % 10000;
          end else begin
            m_ovf = (m_cnt == 0);
            m_cnt = (m_cnt + 9999) % 10000;
          end
        end else begin
          m_pre++;
        end
      end
    end
  end

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  // Digit i is blank when enabled, i>0 and the value is below 10^i
  function automatic logic [31:0] exp_seg(int v, bit blank);
    logic [7:0] tbl [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    logic [31:0] r = '0;
    int p = 1;
    for (int i = 0; i < 4; i++) begin
      if (!(blank && i > 0 && v < p)) r[8*i +: 8] = tbl[(v / p) % 10];
      p *= 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clkIn) begin
    chk("bcd",      32'(bcdOut),      32'(to_bcd(m_cnt)));
    chk("tick",     32'(tickOut),     32'(m_tick));
    chk("ovf",      32'(overflowOut), 32'(m_ovf));
    chk("seg",      segmentsOut,      exp_seg(m_seg_cnt, 1'b1));
    chk("seg_nb",   seg_nb,           exp_seg(m_seg_cnt, 1'b0));
    chk("bcd_nb",   32'(bcd_nb),      32'(to_bcd(m_cnt)));
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clkIn);
    #2;
  endtask

  task automatic wait_bcd(input logic [15:0] target, input int budget);
    int k = 0;
    while (bcdOut !== target && k < budget) begin
      cyc(1);
      k++;
    end
    if (bcdOut !== target) chk("wait_bcd_timeout", 32'(bcdOut), 32'(target));
  endtask

  task automatic wait_tick(input int budget);
    int k = 0;
    do begin
      cyc(1);
      k++;
    end while (tickOut !== 1'b1 && k < budget);
    if (tickOut !== 1'b1) chk("wait_tick_timeout", 32'(tickOut), 32'd1);
  endtask

  task automatic restart(input logic up);
    runIn = 1'b0; clearIn = 1'b0;
    resetIn = 1'b0;
    cyc(1);
    upIn = up; runIn = 1'b1; resetIn = 1'b1;
  endtask

  initial begin
    resetIn = 1'b0; runIn = 1'b0; clearIn = 1'b0; upIn = 1'b1;
    cyc(3);
    chk("rst_bcd",    32'(bcdOut), 32'h0);
    chk("rst_seg",    segmentsOut, 32'h0000_003F);
    chk("rst_seg_nb", seg_nb,      32'h3F3F_3F3F);
    chk("rst_tick",   32'(tickOut), 32'h0);

    // First tick ten clocks after run, segments one cycle later
    resetIn = 1'b1; runIn = 1'b1;
    cyc(9);
    chk("first_notick", 32'(tickOut), 32'h0);
    cyc(1);
    chk("first_bcd",  32'(bcdOut),  32'h0001);
    chk("first_tick", 32'(tickOut), 32'h1);
    cyc(1);
    chk("first_seg",    segmentsOut, 32'h0000_0006);
    chk("first_tick_end", 32'(tickOut), 32'h0);

    // 0999 -> 1000 ripple carry
    wait_bcd(16'h0999, 10100);
    wait_tick(20);
    chk("carry_bcd", 32'(bcdOut), 32'h1000);
    cyc(1);
    chk("carry_seg",    segmentsOut, 32'h063F_3F3F);
    chk("carry_seg_nb", seg_nb,      32'h063F_3F3F);

    // Down wrap 0000 -> 9999, then up wrap back to 0000
    restart(1'b0);
    cyc(10);
    chk("dwrap_bcd", 32'(bcdOut),      32'h9999);
    chk("dwrap_ovf", 32'(overflowOut), 32'h1);
    cyc(1);
    chk("dwrap_seg",     segmentsOut,       32'h6F6F_6F6F);
    chk("dwrap_ovf_end", 32'(overflowOut),  32'h0);
    upIn = 1'b1;
    wait_tick(20);
    chk("uwrap_bcd", 32'(bcdOut),      32'h0000);
    chk("uwrap_ovf", 32'(overflowOut), 32'h1);
    cyc(1);
    chk("uwrap_seg", segmentsOut, 32'h0000_003F);

    // Prescaler hold while run is low
    restart(1'b1);
    cyc(5);
    runIn = 1'b0;
    cyc(20);
    chk("hold_notick", 32'(tickOut), 32'h0);
    chk("hold_bcd",    32'(bcdOut),  32'h0000);
    runIn = 1'b1;
    cyc(4);
    chk("resume_notick", 32'(tickOut), 32'h0);
    cyc(1);
    chk("resume_tick", 32'(tickOut), 32'h1);
    chk("resume_bcd",  32'(bcdOut),  32'h0001);

    // Clear on the exact tick cycle at 0042
    restart(1'b1);
    wait_bcd(16'h0042, 500);
    cyc(9);
    clearIn = 1'b1;
    cyc(1);
    clearIn = 1'b0;
    chk("clr_bcd",  32'(bcdOut),      32'h0000);
    chk("clr_tick", 32'(tickOut),     32'h0);
    chk("clr_ovf",  32'(overflowOut), 32'h0);
    cyc(10);
    chk("clr_next_tick", 32'(tickOut), 32'h1);
    chk("clr_next_bcd",  32'(bcdOut),  32'h0001);

    // Asynchronous reset mid-prescale at 0123
    wait_bcd(16'h0123, 1300);
    cyc(4);
    #1 resetIn = 1'b0;
    #1;
    chk("arst_bcd",    32'(bcdOut),      32'h0000);
    chk("arst_seg",    segmentsOut,      32'h0000_003F);
    chk("arst_seg_nb", seg_nb,           32'h3F3F_3F3F);
    chk("arst_tick",   32'(tickOut),     32'h0);
    chk("arst_ovf",    32'(overflowOut), 32'h0);
    #3 resetIn = 1'b1;
    cyc(9);
    chk("arst_notick", 32'(tickOut), 32'h0);
    cyc(1);
    chk("arst_tick1", 32'(tickOut), 32'h1);
    chk("arst_bcd1",  32'(bcdOut),  32'h0001);

    // Randomized phase, starting downward to pass through the wrap
    upIn = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      runIn   = ($urandom % 8) != 0;
      clearIn = ($urandom % 97) == 0;
      if ($urandom % 13 == 0) upIn = 1'($urandom % 2);
      resetIn = ($urandom % 701) != 0;
      cyc(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
